// File: rtl/vortex_mem_line_bridge.sv
// vortex_mem_line_bridge: splits tagged Vortex line requests into bus-width beats and reassembles read lines.
// Define VX_BRIDGE_PERF_EN to add the read/write line and stall-cycle performance counters.
module vortex_mem_line_bridge #(
  parameter int LINE_WIDTH = 512,
  parameter int BUS_WIDTH = 32,
  parameter int LINE_ADDR_WIDTH = 26,
  parameter int TAG_WIDTH = 56,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       nRST,
  input  logic                       mem_req_valid,
  input  logic                       mem_req_rw,
  input  logic [LINE_WIDTH/8-1:0]    mem_req_byteen,
  input  logic [LINE_ADDR_WIDTH-1:0] mem_req_addr,
  input  logic [LINE_WIDTH-1:0]      mem_req_data,
  input  logic [TAG_WIDTH-1:0]       mem_req_tag,
  output logic                       mem_req_ready,
  output logic                       mem_rsp_valid,
  output logic [LINE_WIDTH-1:0]      mem_rsp_data,
  output logic [TAG_WIDTH-1:0]       mem_rsp_tag,
  output logic                       mem_rsp_error,
  input  logic                       mem_rsp_ready,
  output logic                       bus_ren,
  output logic                       bus_wen,
  output logic [ADDR_WIDTH-1:0]      bus_addr,
  output logic [BUS_WIDTH-1:0]       bus_wdata,
  output logic [BUS_WIDTH/8-1:0]     bus_strobe,
  input  logic [BUS_WIDTH-1:0]       bus_rdata,
  input  logic                       bus_request_stall,
  input  logic                       bus_error,
  output logic                       wr_err_sticky,
  input  logic                       wr_err_clr,
  output logic [31:0]                perf_rd_lines,
  output logic [31:0]                perf_wr_lines,
  output logic [31:0]                perf_stall_cycles
);
  localparam int BEATS = LINE_WIDTH / BUS_WIDTH;
  localparam int LB = $clog2(LINE_WIDTH / 8);
  localparam int WB = BUS_WIDTH / 8;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;
  state_t state, state_d;
  logic [BW-1:0] beat;
  logic rw, rsp_err, skip, done, beat_err;
  logic [LINE_WIDTH/8-1:0] byteen;
  logic [LINE_ADDR_WIDTH-1:0] addr;
  logic [LINE_WIDTH-1:0] data, line;
  logic [TAG_WIDTH-1:0] tag;
  logic [WB-1:0] strobe;
  assign strobe = byteen[beat*WB +: WB];
  // all-zero write beats consume one cycle without touching the bus
  assign skip = rw && strobe == '0;
  assign done = state == XFER && (skip || !bus_request_stall);
  assign beat_err = done && !skip && bus_error;
  assign mem_rsp_data = line;
  assign mem_rsp_tag = tag;
  assign mem_rsp_error = rsp_err;
  always_comb begin
    state_d = state;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    bus_ren = 1'b0;
    bus_wen = 1'b0;
    bus_addr = '0;
    bus_wdata = '0;
    bus_strobe = '0;
    unique case (state)
      IDLE: begin
        mem_req_ready = nRST;
        state_d = mem_req_valid ? XFER : IDLE;
      end
      XFER: begin
        bus_ren = !rw;
        bus_wen = rw && !skip;
        bus_addr = BASE_ADDR + (ADDR_WIDTH'(addr) << LB) + ADDR_WIDTH'(beat) * ADDR_WIDTH'(WB);
        bus_wdata = rw ? data[beat*BUS_WIDTH +: BUS_WIDTH] : '0;
        bus_strobe = rw ? strobe : '1;
        state_d = done && beat == LAST ? (rw ? IDLE : RESP) : XFER;
      end
      RESP: begin
        mem_rsp_valid = 1'b1;
        state_d = mem_rsp_ready ? IDLE : RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      beat <= '0;
      rw <= 1'b0;
      byteen <= '0;
      addr <= '0;
      data <= '0;
      tag <= '0;
      line <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_d;
      if (state == IDLE && mem_req_valid) begin
        rw <= mem_req_rw;
        byteen <= mem_req_byteen;
        addr <= mem_req_addr;
        data <= mem_req_data;
        tag <= mem_req_tag;
        line <= '0;
        rsp_err <= 1'b0;
        beat <= '0;
      end
      if (done) beat <= beat + BW'(1);
      if (done && !skip && !rw) line[beat*BUS_WIDTH +: BUS_WIDTH] <= bus_error ? '0 : bus_rdata;
      if (beat_err && !rw) rsp_err <= 1'b1;
    end
  end
  // a new write error outranks a simultaneous clear
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) wr_err_sticky <= 1'b0;
    else if (beat_err && rw) wr_err_sticky <= 1'b1;
    else if (wr_err_clr) wr_err_sticky <= 1'b0;
  end
`ifdef VX_BRIDGE_PERF_EN
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      perf_rd_lines <= '0;
      perf_wr_lines <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (mem_rsp_valid && mem_rsp_ready) perf_rd_lines <= perf_rd_lines + 32'd1;
      if (done && rw && beat == LAST) perf_wr_lines <= perf_wr_lines + 32'd1;
      if ((bus_ren || bus_wen) && bus_request_stall) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`else
  assign perf_rd_lines = '0;
  assign perf_wr_lines = '0;
  assign perf_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_vortex_mem_line_bridge.sv
// tb_vortex_mem_line_bridge: directed and randomized line transfers checked against a beat-level model of the bridge.
module tb_vortex_mem_line_bridge;
  localparam int BEATS = 16;
  localparam logic [31:0] BASE = 32'hF000_0000;
  logic clk = 1'b0, nRST = 1'b0;
  logic mem_req_valid = 1'b0, mem_req_rw = 1'b0, mem_rsp_ready = 1'b0;
  logic [63:0] mem_req_byteen = '0;
  logic [25:0] mem_req_addr = '0;
  logic [511:0] mem_req_data = '0;
  logic [55:0] mem_req_tag = '0;
  logic mem_req_ready, mem_rsp_valid, mem_rsp_error;
  logic [511:0] mem_rsp_data;
  logic [55:0] mem_rsp_tag;
  logic bus_ren, bus_wen;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0] bus_strobe;
  logic bus_request_stall = 1'b0, bus_error = 1'b0, wr_err_clr = 1'b0;
  logic wr_err_sticky;
  logic [31:0] perf_rd_lines, perf_wr_lines, perf_stall_cycles;
  logic [31:0] rd_seed = '0;
  logic exp_sticky = 1'b0;
  int checks = 0, errors = 0, p_rd = 0, p_wr = 0, p_st = 0;

  vortex_mem_line_bridge #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .nRST(nRST),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_byteen(mem_req_byteen),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_tag(mem_rsp_tag), .mem_rsp_error(mem_rsp_error), .mem_rsp_ready(mem_rsp_ready),
    .bus_ren(bus_ren), .bus_wen(bus_wen), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_strobe(bus_strobe), .bus_rdata(bus_rdata), .bus_request_stall(bus_request_stall),
    .bus_error(bus_error), .wr_err_sticky(wr_err_sticky), .wr_err_clr(wr_err_clr),
    .perf_rd_lines(perf_rd_lines), .perf_wr_lines(perf_wr_lines), .perf_stall_cycles(perf_stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rword(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ rd_seed;
  endfunction
  assign bus_rdata = rword(bus_addr);

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_perf();
`ifdef VX_BRIDGE_PERF_EN
    chk("perf_rd_lines", perf_rd_lines, 512'(p_rd));
    chk("perf_wr_lines", perf_wr_lines, 512'(p_wr));
    chk("perf_stall_cycles", perf_stall_cycles, 512'(p_st));
`else
    chk("perf_rd_lines", perf_rd_lines, '0);
    chk("perf_wr_lines", perf_wr_lines, '0);
    chk("perf_stall_cycles", perf_stall_cycles, '0);
`endif
  endtask

  task automatic rand_line(output logic [511:0] d);
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
  endtask

  task automatic rand_tag(output logic [55:0] t);
    t = {24'($urandom), $urandom};
  endtask

  // Entered and left at a negedge with the bridge idle; every cycle checks outputs then drives inputs.
  task automatic xfer(input logic rw, input logic [63:0] be, input logic [25:0] a, input logic [511:0] d,
                      input logic [55:0] t, input int stall_beat, input int stall_n, input int err_beat,
                      input int rdy_delay, input int abort_at, input logic clr_on_err);
    logic [511:0] exp_line;
    logic exp_err, stall;
    logic [3:0] st;
    logic [31:0] ba;
    int b, left, cyc, stalls;
    b = 0; left = stall_n; cyc = 0; stalls = 0; exp_line = '0; exp_err = 1'b0;
    chk("req_ready_idle", mem_req_ready, 1'b1);
    mem_req_valid = 1'b1; mem_req_rw = rw; mem_req_byteen = be;
    mem_req_addr = a; mem_req_data = d; mem_req_tag = t;
    @(negedge clk); cyc = 1;
    mem_req_rw = ~rw; mem_req_byteen = ~be; mem_req_addr = ~a; mem_req_data = ~d; mem_req_tag = ~t;
    while (b < BEATS && cyc < 200) begin
      if (b == abort_at) begin
        nRST = 1'b0;
        #1;
        chk("rst_ren", bus_ren, 1'b0);
        chk("rst_addr", bus_addr, '0);
        chk("rst_req_ready", mem_req_ready, 1'b0);
        chk("rst_rsp_valid", mem_rsp_valid, 1'b0);
        chk("rst_rsp_data", mem_rsp_data, '0);
        chk("rst_rsp_tag", mem_rsp_tag, '0);
        p_rd = 0; p_wr = 0; p_st = 0; exp_sticky = 1'b0;
        chk("rst_sticky", wr_err_sticky, 1'b0);
        chk_perf();
        mem_req_valid = 1'b0; bus_request_stall = 1'b0; bus_error = 1'b0; wr_err_clr = 1'b0;
        @(negedge clk);
        nRST = 1'b1;
        #1 chk("rst_release_ready", mem_req_ready, 1'b1);
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          chk("rst_no_rsp", {mem_rsp_valid, bus_ren, bus_wen}, '0);
        end
        return;
      end
      ba = BASE + {a, 6'b0} + 32'(b * 4);
      st = rw ? be[b*4 +: 4] : 4'hF;
      chk("req_ready_busy", mem_req_ready, 1'b0);
      if (rw && st == 4'h0) begin
        chk("skip_idle", {bus_ren, bus_wen}, '0);
        bus_request_stall = 1'b0; bus_error = 1'b0; wr_err_clr = 1'b0;
        b++;
      end else begin
        chk("ren", bus_ren, !rw);
        chk("wen", bus_wen, rw);
        chk("addr", bus_addr, ba);
        chk("strobe", bus_strobe, st);
        if (rw) chk("wdata", bus_wdata, d[b*32 +: 32]);
        stall = b == stall_beat && left > 0;
        bus_request_stall = stall;
        bus_error = !stall && b == err_beat;
        wr_err_clr = clr_on_err && bus_error;
        if (stall) begin
          left--; stalls++; p_st++;
        end else begin
          if (bus_error && rw) exp_sticky = 1'b1;
          else if (bus_error) exp_err = 1'b1;
          else if (!rw) exp_line[b*32 +: 32] = rword(ba);
          b++;
        end
      end
      @(negedge clk); cyc++;
    end
    mem_req_valid = 1'b0; bus_request_stall = 1'b0; bus_error = 1'b0; wr_err_clr = 1'b0;
    chk("beats_done", 512'(b), 512'(BEATS));
    chk("latency", 512'(cyc), 512'(BEATS + 1 + stalls));
    chk("wr_err_sticky", wr_err_sticky, exp_sticky);
    if (rw) begin
      p_wr++;
      chk("wr_ready_back", mem_req_ready, 1'b1);
      chk("wr_no_rsp", {mem_rsp_valid, bus_ren, bus_wen}, '0);
    end else begin
      chk("rsp_valid", mem_rsp_valid, 1'b1);
      chk("rsp_data", mem_rsp_data, exp_line);
      chk("rsp_tag", mem_rsp_tag, t);
      chk("rsp_error", mem_rsp_error, exp_err);
      chk("rsp_req_ready", mem_req_ready, 1'b0);
      for (int i = 0; i < rdy_delay; i++) begin
        @(negedge clk);
        chk("hold_valid", mem_rsp_valid, 1'b1);
        chk("hold_data", mem_rsp_data, exp_line);
        chk("hold_tag", mem_rsp_tag, t);
        chk("hold_req_ready", mem_req_ready, 1'b0);
      end
      mem_rsp_ready = 1'b1;
      @(negedge clk);
      mem_rsp_ready = 1'b0;
      p_rd++;
      chk("post_rsp_valid", mem_rsp_valid, 1'b0);
      chk("post_rsp_ready", mem_req_ready, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] d;
    logic [55:0] t;
    logic [63:0] be;
    int sel;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", mem_req_ready, 1'b0);
    chk("reset_rsp", {mem_rsp_valid, mem_rsp_error, mem_rsp_tag}, '0);
    chk("reset_rsp_data", mem_rsp_data, '0);
    chk("reset_bus", {bus_ren, bus_wen, bus_addr, bus_wdata, bus_strobe}, '0);
    chk("reset_sticky", wr_err_sticky, 1'b0);
    chk_perf();
    nRST = 1'b1;
    #1 chk("reset_release_ready", mem_req_ready, 1'b1);
    @(negedge clk);
    rd_seed = $urandom; rand_line(d); rand_tag(t);
    xfer(1'b0, '1, 26'h10, d, t, -1, 0, -1, 0, -1, 1'b0);
    rand_line(d); rand_tag(t);
    xfer(1'b1, 64'h0000_0000_0000_F00F, 26'h10, d, t, -1, 0, -1, 0, -1, 1'b0);
    rd_seed = $urandom; rand_line(d); rand_tag(t);
    xfer(1'b0, '1, 26'($urandom), d, t, 5, 3, -1, 0, -1, 1'b0);
    chk_perf();
    rd_seed = $urandom; rand_line(d); rand_tag(t);
    xfer(1'b0, '1, 26'($urandom), d, t, -1, 0, 2, 5, -1, 1'b0);
    rand_line(d); rand_tag(t);
    xfer(1'b1, 64'h0000_0000_0000_F00F, 26'($urandom), d, t, -1, 0, 3, 0, -1, 1'b0);
    wr_err_clr = 1'b1;
    @(negedge clk);
    wr_err_clr = 1'b0; exp_sticky = 1'b0;
    chk("sticky_cleared", wr_err_sticky, 1'b0);
    rand_line(d); rand_tag(t);
    xfer(1'b1, '1, 26'($urandom), d, t, -1, 0, 9, 0, -1, 1'b1);
    wr_err_clr = 1'b1;
    @(negedge clk);
    wr_err_clr = 1'b0; exp_sticky = 1'b0;
    chk("sticky_cleared2", wr_err_sticky, 1'b0);
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 16; i++) begin
        sel = $urandom_range(0, 2);
        be[i*4 +: 4] = sel == 0 ? 4'h0 : sel == 1 ? 4'hF : 4'($urandom);
      end
      rd_seed = $urandom; rand_line(d); rand_tag(t);
      xfer(1'($urandom), be, 26'($urandom), d, t, $urandom_range(0, 15), $urandom_range(0, 3),
           $urandom_range(0, 31), $urandom_range(0, 3), -1, 1'b0);
    end
    chk_perf();
    rd_seed = $urandom; rand_line(d); rand_tag(t);
    xfer(1'b0, '1, 26'($urandom), d, t, -1, 0, -1, 0, 7, 1'b0);
    rd_seed = $urandom; rand_line(d); rand_tag(t);
    xfer(1'b0, '1, 26'($urandom), d, t, 1, 2, -1, 1, -1, 1'b0);
    chk_perf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
